// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-read-port register file.
// Optional feature macro: ZERO_REG_EN (register 0 hardwired to zero).
package reg_file_mp_pkg;

  localparam logic OFF = 1'b0;
  localparam logic ON  = 1'b1;

  localparam int BIT_DATA = 8;
  localparam int SZB_DEF  = 4;
  localparam int SZA_DEF  = 2 ** SZB_DEF;

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle between the decode-side driver and the register file.
// Optional feature macro: ZERO_REG_EN (no effect on the bundle itself).
interface reg_file_mp_if #(
  parameter int BIT = 8,
  parameter int SZB = 4,
  parameter int NRP = 2
);
  localparam int SZA = 2 ** SZB;

  logic [NRP-1:0]     re;
  logic [NRP*SZB-1:0] addr_rs;
  logic [NRP*BIT-1:0] rs;
  logic [NRP-1:0]     rs_vld;
  logic               we;
  logic [SZB-1:0]     addr_rd;
  logic [BIT-1:0]     rd;
  logic               lock;
  logic [SZB-1:0]     addr_lk;
  logic [SZA-1:0]     busy;
  logic [SZA*BIT-1:0] dbg_regs;

  modport master (
    output re, addr_rs, we, addr_rd, rd, lock, addr_lk,
    input  rs, rs_vld, busy, dbg_regs
  );

  modport slave (
    input  re, addr_rs, we, addr_rd, rd, lock, addr_lk,
    output rs, rs_vld, busy, dbg_regs
  );
endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Write-pending scoreboard: one busy bit per register, set by lock, cleared by write.
// Optional feature macro: ZERO_REG_EN (filtering is done by the parent).
module reg_scoreboard
  import reg_file_mp_pkg::*;
#(
  parameter int SZB = SZB_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              lock,
  input  logic [SZB-1:0]    addr_lk,
  input  logic              we,
  input  logic [SZB-1:0]    addr_rd,
  output logic [2**SZB-1:0] busy,
  output logic [2**SZB-1:0] eff_busy
);
  localparam int SZA = 2 ** SZB;

  logic [SZA-1:0] busy_q;
  logic [SZA-1:0] busy_d;

  // NOTE: busy_d starts from busy_q so every path assigns it and no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    if (we)   busy_d[addr_rd] = OFF;
    // Applied after the clear so a same-cycle lock wins over the write.
    if (lock) busy_d[addr_lk] = ON;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy     = busy_q;
  // The next-state vector already folds in same-cycle writes and locks.
  assign eff_busy = busy_d;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with write-first bypass and busy scoreboard.
// Optional feature macro: ZERO_REG_EN (register 0 hardwired to zero).
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int BIT = BIT_DATA,
  parameter int SZB = SZB_DEF,
  parameter int NRP = 2
) (
  input  logic       clock,
  input  logic       reset,
  reg_file_mp_if.slave bus
);
  localparam int SZA = 2 ** SZB;

  logic           we_eff;
  logic           lock_eff;
  logic [SZA-1:0] eff_busy;

`ifdef ZERO_REG_EN
  assign we_eff   = bus.we   && (bus.addr_rd != '0);
  assign lock_eff = bus.lock && (bus.addr_lk != '0);
`else
  assign we_eff   = bus.we;
  assign lock_eff = bus.lock;
`endif

  reg_scoreboard #(.SZB(SZB)) u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .lock     (lock_eff),
    .addr_lk  (bus.addr_lk),
    .we       (we_eff),
    .addr_rd  (bus.addr_rd),
    .busy     (bus.busy),
    .eff_busy (eff_busy)
  );

  logic [BIT-1:0] regf_q [SZA];
  logic [BIT-1:0] regf_d [SZA];

  always_comb begin
    regf_d = regf_q;
    if (we_eff) regf_d[bus.addr_rd] = bus.rd;
  end

  // NOTE: the array is reset because the first read after reset must return 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SZA; i++) regf_q[i] <= '0;
    end else begin
      regf_q <= regf_d;
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rport
    logic [SZB-1:0] addr;
    logic [BIT-1:0] rs_q, rs_d;
    logic           vld_q, vld_d;
    logic           byp;

    assign addr = bus.addr_rs[SZB*p +: SZB];
    assign byp  = we_eff && (bus.addr_rd == addr);

    always_comb begin
      rs_d  = rs_q;
      vld_d = OFF;
      if (bus.re[p]) begin
        rs_d  = byp ? bus.rd : regf_q[addr];
        vld_d = ~eff_busy[addr];
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        rs_q  <= '0;
        vld_q <= OFF;
      end else begin
        rs_q  <= rs_d;
        vld_q <= vld_d;
      end
    end

    assign bus.rs[BIT*p +: BIT] = rs_q;
    assign bus.rs_vld[p]        = vld_q;
  end

  for (genvar i = 0; i < SZA; i++) begin : g_dbg
    assign bus.dbg_regs[BIT*i +: BIT] = regf_q[i];
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp; expected values are hand-computed per step.
// Optional feature macro: ZERO_REG_EN (selects the register-0 expectations).
module tb_reg_file_mp;
  localparam int BIT = 8;
  localparam int SZB = 4;
  localparam int NRP = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total  = 0;
  int   passed = 0;

  reg_file_mp_if #(.BIT(BIT), .SZB(SZB), .NRP(NRP)) bus ();

  reg_file_mp #(.BIT(BIT), .SZB(SZB), .NRP(NRP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.re      = '0;
    bus.addr_rs = '0;
    bus.we      = 1'b0;
    bus.addr_rd = '0;
    bus.rd      = '0;
    bus.lock    = 1'b0;
    bus.addr_lk = '0;
  endtask

  task automatic rd_ports(input logic [1:0] re, input logic [3:0] a0, input logic [3:0] a1);
    bus.re      = re;
    bus.addr_rs = {a1, a0};
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.we      = 1'b1;
    bus.addr_rd = a;
    bus.rd      = d;
  endtask

  task automatic lk(input logic [3:0] a);
    bus.lock    = 1'b1;
    bus.addr_lk = a;
  endtask

  initial begin
    idle();
    #2;
    check("reset_rs",     64'(bus.rs),       64'h0);
    check("reset_vld",    64'(bus.rs_vld),   64'h0);
    check("reset_busy",   64'(bus.busy),     64'h0);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Every address reads zero and valid after reset.
    for (int i = 0; i < 16; i++) begin
      rd_ports(2'b11, 4'(i), 4'(15 - i));
      tick();
      check($sformatf("init_rs_%0d", i), 64'(bus.rs),     64'h0);
      check($sformatf("init_vld_%0d", i), 64'(bus.rs_vld), 64'h3);
    end
    check("init_busy", 64'(bus.busy), 64'h0);

    // Write then read on the next cycle; port1 idle.
    idle(); wr(4'd3, 8'h5A);
    tick();
    idle(); rd_ports(2'b01, 4'd3, 4'd0);
    tick();
    check("wr_rd_rs0",  64'(bus.rs[7:0]), 64'h5A);
    check("wr_rd_vld",  64'(bus.rs_vld),  64'h1);

    // Same-cycle bypass to both ports.
    idle(); wr(4'd7, 8'hC3); rd_ports(2'b11, 4'd7, 4'd7);
    tick();
    check("byp_rs",     64'(bus.rs),                64'hC3C3);
    check("byp_vld",    64'(bus.rs_vld),            64'h3);
    check("byp_dbg_r7", 64'(bus.dbg_regs[56 +: 8]), 64'hC3);

    // Lock, busy read, then write-with-read clears it.
    idle(); lk(4'd5);
    tick();
    check("lock_busy5", 64'(bus.busy[5]), 64'h1);
    idle(); rd_ports(2'b01, 4'd5, 4'd0);
    tick();
    check("busy_rd_vld", 64'(bus.rs_vld), 64'h0);
    idle(); wr(4'd5, 8'h11); rd_ports(2'b01, 4'd5, 4'd0);
    tick();
    check("unlock_rs0",   64'(bus.rs[7:0]), 64'h11);
    check("unlock_vld",   64'(bus.rs_vld),  64'h1);
    check("unlock_busy5", 64'(bus.busy[5]), 64'h0);

    // Read in the same cycle as a lock of that address.
    idle(); lk(4'd6); rd_ports(2'b10, 4'd0, 4'd6);
    tick();
    check("lock_rd_vld", 64'(bus.rs_vld), 64'h0);

    // Lock and write on the same address: lock wins, data lands.
    idle(); lk(4'd9); wr(4'd9, 8'h22);
    tick();
    check("lkwr_busy9", 64'(bus.busy[9]),         64'h1);
    check("lkwr_dbg9",  64'(bus.dbg_regs[72 +: 8]), 64'h22);
    idle(); rd_ports(2'b01, 4'd9, 4'd0);
    tick();
    check("lkwr_rd_rs0", 64'(bus.rs[7:0]), 64'h22);
    check("lkwr_rd_vld", 64'(bus.rs_vld),  64'h0);

    // re=0 holds data and drops valid.
    idle();
    tick();
    check("hold_rs0", 64'(bus.rs[7:0]), 64'h22);
    check("hold_vld", 64'(bus.rs_vld),  64'h0);

    // Register 0 behaviour.
    idle(); wr(4'd0, 8'hFF); lk(4'd0);
    tick();
    idle(); rd_ports(2'b01, 4'd0, 4'd0);
    tick();
`ifdef ZERO_REG_EN
    check("r0_rs0",   64'(bus.rs[7:0]),        64'h00);
    check("r0_vld",   64'(bus.rs_vld),         64'h1);
    check("r0_busy0", 64'(bus.busy[0]),        64'h0);
    check("r0_dbg0",  64'(bus.dbg_regs[7:0]),  64'h00);
`else
    check("r0_rs0",   64'(bus.rs[7:0]),        64'hFF);
    check("r0_vld",   64'(bus.rs_vld),         64'h0);
    check("r0_busy0", 64'(bus.busy[0]),        64'h1);
    check("r0_dbg0",  64'(bus.dbg_regs[7:0]),  64'hFF);
`endif

    // Asynchronous reset in the middle of a cycle.
    idle(); wr(4'd3, 8'h77); rd_ports(2'b11, 4'd3, 4'd3);
    tick();
    check("pre_rst_rs", 64'(bus.rs), 64'h7777);
    idle();
    #2 reset = 1'b1;
    #1;
    check("arst_rs",   64'(bus.rs),       64'h0);
    check("arst_vld",  64'(bus.rs_vld),   64'h0);
    check("arst_busy", 64'(bus.busy),     64'h0);
    check("arst_dbg",  64'(bus.dbg_regs[63:0]), 64'h0);
    #1 reset = 1'b0;
    rd_ports(2'b11, 4'd3, 4'd9);
    tick();
    check("post_rst_rs",  64'(bus.rs),     64'h0);
    check("post_rst_vld", 64'(bus.rs_vld), 64'h3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file with a write-pending scoreboard, for the CPU datapath between decode and execute. It generalises the single-write, two-read data register file: read-port count is a parameter, same-cycle writes are bypassed to readers, and each register carries a busy bit so that readers see a valid flag rather than stale data. Reads are registered, with one cycle of latency.

## Interface
- BIT, 8, data width per register
- SZB, 4, address width; depth SZA = 2**SZB
- NRP, 2, number of read ports (1..4)

- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- re  input  NRP  per-port read enable
- addr_rs  input  NRP*SZB  read addresses; port p occupies bits [SZB*(p+1)-1 : SZB*p]
- rs  output  NRP*BIT  registered read data, packed the same way as addr_rs
- rs_vld  output  NRP  read data valid, per port
- we  input  1  write enable
- addr_rd  input  SZB  write address
- rd  input  BIT  write data
- lock  input  1  mark register addr_lk as pending a write
- addr_lk  input  SZB  lock address
- busy  output  SZA  scoreboard vector; bit i is set while register i is pending
- dbg_regs  output  SZA*BIT  flattened register contents for the bench; register i occupies [BIT*(i+1)-1 : BIT*i]

## Operation
- Reset values: all registers 0, busy 0, rs 0, rs_vld 0.
- Write: when we=1, regf[addr_rd] <= rd at the clock edge, and busy[addr_rd] is cleared.
- Lock: when lock=1, busy[addr_lk] is set at the clock edge.
  - If lock and we target the same address in the same cycle, lock wins: busy stays 1 and the data is written.
- Read port p with re[p]=1 at edge N:
  - rs[p] takes the effective value of regf[addr_rs[p]].
  - rs_vld[p] = ~effective_busy.
- Bypass (write-first): if we=1 and addr_rd equals addr_rs[p] in the same cycle:
  - rs[p] takes rd, not the old contents.
  - effective_busy = 0, unless a same-cycle lock also targets that address.
- Busy read: rs[p] still loads the current stored value, but rs_vld[p]=0. The consumer must retry the read.
- re[p]=0: rs[p] holds its previous value and rs_vld[p] goes to 0.
- Read ports are independent. Any number of ports may read the same address in one cycle.
- A lock on an address that is already busy leaves it busy; there is no counter.
- A write to an address that is not busy is legal and simply updates the data.

## Timing
- Read latency is 1 cycle: address and re are sampled at edge N, and rs and rs_vld are valid after edge N.
- Write-to-read latency is 0 cycles, through the bypass; the written data is visible in dbg_regs after the edge.
- Lock-to-busy latency is 1 edge. A read in the same cycle as a lock to the same address returns rs_vld=0.
- Reset mid-operation clears all state immediately (asynchronous). The first read after reset deassertion returns 0 with rs_vld=1.

## Configuration
- ZERO_REG_EN defined: register 0 is hardwired.
  - Writes to address 0 are ignored.
  - Locks to address 0 are ignored, so busy[0] is always 0.
  - Reads of address 0 return 0 with rs_vld=1, including while a bypass write to address 0 is in flight.
  - dbg_regs bits [BIT-1:0] are always 0.
- ZERO_REG_EN undefined: register 0 is an ordinary register.

## Structure
- Shared definitions package:
  - OFF/ON constants.
  - BIT_DATA default.
  - Helper localparam for SZA.
- Sub-module reg_scoreboard holds the busy vector.
  - Inputs: lock/addr_lk, we/addr_rd.
  - Outputs: busy, plus a per-address "effective busy" including same-cycle updates, consumed by the read ports.
- Top level contains the storage array, the NRP read-port generate loop with bypass compare, and the dbg_regs generate loop.

## Test plan
- Reset, then read all 16 addresses on both ports -> rs=0x00 and rs_vld=1 for every read; busy=0.
- Write 0x5A to r3, then read r3 on port0 in the next cycle -> rs0=0x5A, rs_vld0=1; port1 idle -> rs_vld1=0.
- Same cycle: we to r7 with 0xC3, and both ports read r7 -> both ports return 0xC3 with vld=1 after the edge.
- lock r5, then read r5 -> rs_vld=0; write 0x11 to r5 while port0 reads r5 -> rs0=0x11, vld=1, busy[5]=0.
- Same cycle: lock and we both on r9 with 0x22 -> busy[9]=1 and dbg_regs r9=0x22; next read of r9 -> vld=0.
- With ZERO_REG_EN: write 0xFF and lock on r0, then read r0 -> rs=0x00, vld=1, busy[0]=0. Assert reset mid-stream -> all outputs return to 0 at once.
